// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 sequencer constants, round-constant table and FSM state type
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES128_ROUNDS = 10;

    // Indexed by round-1
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2,
        ZERO  = 2'd3
    } seq_state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [3:0] idx;
        idx = rnd - 4'd1;
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// rtl/aes_rr_arb2.sv - two-way round-robin arbiter; pointer moves away from the winner on advance
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic rr_ptr;

    always_comb begin
        grant_id = (valid == 2'b11) ? rr_ptr : valid[1];
        grant    = 2'b00;
        if (enable && (valid != 2'b00)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (advance) begin
            rr_ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round sequencer for two round-robin requesters
// AES_ZEROIZE_EN: adds one ZERO cycle after each response that clears the working registers.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_pt,
    input  logic [DATA_W-1:0] req0_key,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_pt,
    input  logic [DATA_W-1:0] req1_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_ct,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rd_state,
    output logic [DATA_W-1:0] rd_rkey,
    output logic              rd_final,
    input  logic [DATA_W-1:0] rd_result,
    output logic [DATA_W-1:0] ks_key,
    output logic [7:0]        ks_rcon,
    input  logic [DATA_W-1:0] ks_next,
    output logic              busy,
    output logic [3:0]        round
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    if (NUM_ROUNDS != AES128_ROUNDS || DATA_W != AES_BLK_W) begin : g_cfg_check
        $error("aes_round_sequencer supports only NUM_ROUNDS=10 and DATA_W=128");
    end

    seq_state_t        fsm;
    logic [DATA_W-1:0] state_reg;
    logic [DATA_W-1:0] key_reg;
    logic [1:0]        grant;
    logic              grant_id;
    logic              accept;
    logic              in_round;
    logic [DATA_W-1:0] sel_pt;
    logic [DATA_W-1:0] sel_key;

    // Gating with rst_n keeps both readies low while reset is held
    aes_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    ({req1_valid, req0_valid}),
        .enable   ((fsm == IDLE) && rst_n),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel_pt     = grant_id ? req1_pt  : req0_pt;
    assign sel_key    = grant_id ? req1_key : req0_key;
    assign busy       = (fsm != IDLE);
    assign in_round   = (fsm == ROUND);

    // The key-step result feeds the round datapath in the same cycle
    always_comb begin
        ks_key   = in_round ? key_reg   : '0;
        ks_rcon  = in_round ? aes_rcon(round) : 8'h00;
        rd_state = in_round ? state_reg : '0;
        rd_rkey  = in_round ? ks_next   : '0;
        rd_final = in_round && (round == LAST_ROUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rsp_ct    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            round     <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        state_reg <= sel_pt ^ sel_key;
                        key_reg   <= sel_key;
                        rsp_id    <= grant_id;
                        round     <= 4'd1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= rd_result;
                    key_reg   <= ks_next;
                    if (round == LAST_ROUND) begin
                        rsp_ct    <= rd_result;
                        rsp_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        round     <= 4'd0;
`ifdef AES_ZEROIZE_EN
                        fsm       <= ZERO;
`else
                        fsm       <= IDLE;
`endif
                    end
                end
                default: begin
                    state_reg <= '0;
                    key_reg   <= '0;
                    rsp_ct    <= '0;
                    fsm       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - scoreboard bench with behavioural AES round/key-step models
module tb_aes_round_sequencer;

    localparam int M_HOLD = 0;
    localparam int M_AUTO = 1;
    localparam int M_RAND = 2;
    localparam int P_IDLE  = 0;
    localparam int P_ROUND = 1;
    localparam int P_DONE  = 2;
    localparam int P_ZERO  = 3;
`ifdef AES_ZEROIZE_EN
    localparam int MIN_GAP = 13;
`else
    localparam int MIN_GAP = 12;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_pt, req0_key, req1_pt, req1_key;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [127:0] rsp_ct, rd_state, rd_rkey, rd_result, ks_key, ks_next;
    logic         rd_final, busy;
    logic [7:0]   ks_rcon;
    logic [3:0]   round;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic         id;
        logic [127:0] ct;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pt(req0_pt), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pt(req1_pt), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_id(rsp_id),
        .rd_state(rd_state), .rd_rkey(rd_rkey), .rd_final(rd_final), .rd_result(rd_result),
        .ks_key(ks_key), .ks_rcon(ks_rcon), .ks_next(ks_next),
        .busy(busy), .round(round)
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (a^254) then the affine map
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv, base, e;
        inv  = 8'h01;
        base = a;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox_f(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_f(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
        logic [127:0] t;
        t = sub_shift(s);
        return (fin ? t : mix(t)) ^ k;
    endfunction

    function automatic logic [127:0] key_step_f(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox_f(w3[23:16]), sbox_f(w3[15:8]), sbox_f(w3[7:0]), sbox_f(w3[31:24])}
             ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < r; i++) c = xtime(c);
        return c;
    endfunction

    function automatic logic [127:0] encrypt_f(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= 10; r++) begin
            k = key_step_f(k, rcon_ref(r));
            s = round_f(s, k, r == 10);
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    assign rd_result = round_f(rd_state, rd_rkey, rd_final);
    assign ks_next   = key_step_f(ks_key, ks_rcon);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level expectation of handshakes and sequencing; pushes expected ciphertexts
    int   ph = P_IDLE, r_m = 0, cyc = 0, last_acc = 0;
    logic rr_m = 1'b0, had_acc = 1'b0;
    always @(negedge clk) begin
        logic e0, e1, gid;
        cyc++;
        if (!rst_n) begin
            ph = P_IDLE; r_m = 0; rr_m = 1'b0; had_acc = 1'b0;
        end else begin
            e0  = 1'b0;
            e1  = 1'b0;
            gid = (req0_valid && req1_valid) ? rr_m : req1_valid;
            if (ph == P_IDLE && (req0_valid || req1_valid)) begin
                e0 = !gid;
                e1 = gid;
            end
            chk("req0_ready", 128'(req0_ready), 128'(e0));
            chk("req1_ready", 128'(req1_ready), 128'(e1));
            chk("busy", 128'(busy), 128'(ph != P_IDLE));
            chk("round", 128'(round), 128'(r_m));
            chk("rsp_valid", 128'(rsp_valid), 128'(ph == P_DONE));
            chk("ks_rcon", 128'(ks_rcon), 128'(ph == P_ROUND ? rcon_ref(r_m) : 8'h00));
            chk("rd_final", 128'(rd_final), 128'(ph == P_ROUND && r_m == 10));
            case (ph)
                P_IDLE: if (e0 || e1) begin
                    sb.push_back('{id: gid, ct: gid ? encrypt_f(req1_pt, req1_key)
                                                    : encrypt_f(req0_pt, req0_key)});
                    if (had_acc) chk("accept_gap", 128'(cyc - last_acc >= MIN_GAP), 128'(1));
                    had_acc = 1'b1; last_acc = cyc; rr_m = !gid; ph = P_ROUND; r_m = 1;
                end
                P_ROUND: if (r_m == 10) ph = P_DONE; else r_m++;
                P_DONE: if (rsp_ready) begin
                    r_m = 0;
`ifdef AES_ZEROIZE_EN
                    ph = P_ZERO;
`else
                    ph = P_IDLE;
`endif
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Response monitor: every presented response must match the oldest outstanding job
    int           n_rsp = 0;
    logic [127:0] last_ct = '0;
    logic         last_id = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(1), 128'(0));
            end else begin
                chk("rsp_ct", rsp_ct, sb[0].ct);
                chk("rsp_id", 128'(rsp_id), 128'(sb[0].id));
                if (rsp_ready) begin
                    last_ct = rsp_ct;
                    last_id = rsp_id;
                    n_rsp++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick(input int mode);
        logic a0, a1;
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        case (mode)
            M_HOLD: begin
                if (a0) req0_valid = 1'b0;
                if (a1) req1_valid = 1'b0;
            end
            M_AUTO: begin
                if (a0) begin req0_pt = rnd128(); req0_key = rnd128(); end
                if (a1) begin req1_pt = rnd128(); req1_key = rnd128(); end
            end
            default: begin
                if (a0 || !req0_valid) begin
                    req0_valid = ($urandom_range(0, 9) < 3);
                    if (req0_valid) begin req0_pt = rnd128(); req0_key = rnd128(); end
                end else if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
                if (a1 || !req1_valid) begin
                    req1_valid = ($urandom_range(0, 9) < 3);
                    if (req1_valid) begin req1_pt = rnd128(); req1_key = rnd128(); end
                end else if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        endcase
    endtask

    task automatic start_job(input logic id, input logic [127:0] pt, input logic [127:0] key);
        if (id) begin req1_valid = 1'b1; req1_pt = pt; req1_key = key; end
        else    begin req0_valid = 1'b1; req0_pt = pt; req0_key = key; end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        do begin
            tick(M_HOLD);
            n++;
        end while ((busy || sb.size() != 0 || req0_valid || req1_valid) && n < budget);
        if (n >= budget) chk("drain_timeout", 128'(1), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_pt = '0; req0_key = '0; req1_pt = '0; req1_key = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_round", 128'(round), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_ct", rsp_ct, 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_req0_ready", 128'(req0_ready), 128'(0));
        chk("rst_req1_ready", 128'(req1_ready), 128'(0));
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // FIPS-197 C.1 on requester 0
        n0 = n_rsp;
        start_job(1'b0, C1_PT, C1_KEY);
        drain(100);
        chk("c1_count", 128'(n_rsp - n0), 128'(1));
        chk("c1_ct", last_ct, C1_CT);
        chk("c1_id", 128'(last_id), 128'(0));

        // FIPS-197 B on requester 1
        n0 = n_rsp;
        start_job(1'b1, B_PT, B_KEY);
        drain(100);
        chk("b_count", 128'(n_rsp - n0), 128'(1));
        chk("b_ct", last_ct, B_CT);
        chk("b_id", 128'(last_id), 128'(1));

        // Both requesters saturating
        start_job(1'b0, rnd128(), rnd128());
        start_job(1'b1, rnd128(), rnd128());
        repeat (80) tick(M_AUTO);
        drain(100);

        // Consumer stall in DONE with the other requester waiting
        rsp_ready = 1'b0;
        start_job(1'b0, rnd128(), rnd128());
        n = 0;
        while (!rsp_valid && n < 30) begin tick(M_HOLD); n++; end
        if (n >= 30) chk("stall_timeout", 128'(1), 128'(0));
        start_job(1'b1, rnd128(), rnd128());
        repeat (20) begin
            tick(M_HOLD);
            chk("stall_valid", 128'(rsp_valid), 128'(1));
        end
        drain(100);

        // Asynchronous reset in round 5 discards the job
        start_job(1'b0, rnd128(), rnd128());
        n = 0;
        while (round != 4'd5 && n < 30) begin tick(M_HOLD); n++; end
        if (n >= 30) chk("round5_timeout", 128'(1), 128'(0));
        n0 = n_rsp;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_round", 128'(round), 128'(0));
        chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("mid_rst_rd_state", rd_state, 128'(0));
        chk("mid_rst_ks_rcon", 128'(ks_rcon), 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) tick(M_HOLD);
        chk("mid_rst_no_rsp", 128'(n_rsp - n0), 128'(0));
        start_job(1'b0, C1_PT, C1_KEY);
        drain(100);
        chk("post_rst_count", 128'(n_rsp - n0), 128'(1));
        chk("post_rst_ct", last_ct, C1_CT);

        // Random traffic and backpressure
        repeat (400) tick(M_RAND);
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
